// File: rtl/bcd_cascade_counter_pkg.sv
// Shared constants for the cascaded BCD counter: digit width, decade limit, direction codes.
package bcd_cascade_counter_pkg;

    localparam int unsigned         DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0]  DIGIT_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0]  DIGIT_MIN = 4'd0;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Clamp a raw nibble into the decimal range.
    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] nib);
        return (nib > DIGIT_MAX) ? DIGIT_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_cascade_counter_digit.sv
// One decade of the cascade: clear, clamped load, and step up/down with carry/borrow out.
module bcd_digit
    import bcd_cascade_counter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_nib_i,
    input  logic               step_i,
    input  logic               up_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               carry_c_o
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;
    logic               at_edge_c;

    // A digit passes a step on only when it is about to roll over in the current direction.
    assign at_edge_c = (up_i == DIR_UP) ? (digit_q == DIGIT_MAX) : (digit_q == DIGIT_MIN);
    assign carry_c_o = step_i & at_edge_c;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = DIGIT_MIN;
        end else if (load_i) begin
            digit_d = bcd_clamp(load_nib_i);
        end else if (step_i) begin
            if (up_i == DIR_UP) begin
                digit_d = at_edge_c ? DIGIT_MIN : DIGIT_W'(digit_q + 4'd1);
            end else begin
                digit_d = at_edge_c ? DIGIT_MAX : DIGIT_W'(digit_q - 4'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= DIGIT_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_cascade_counter.sv
// Up/down decade counter built from DIGITS chained bcd_digit cells on one clock,
// with wrap or saturate at terminal count and a sticky overflow flag.
module bcd_cascade_counter
    import bcd_cascade_counter_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      clr,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic                      tc,
    output logic                      ovf
);

    logic [DIGITS:0] step_c;
    logic            all_max_c;
    logic            all_min_c;
    logic            at_term_c;
    logic            ovf_set_c;
    logic            ovf_q;
    logic            ovf_d;

    // Terminal detection over the whole count, direction-dependent.
    always_comb begin
        all_max_c = 1'b1;
        all_min_c = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            all_max_c = all_max_c & (count[i*DIGIT_W +: DIGIT_W] == DIGIT_MAX);
            all_min_c = all_min_c & (count[i*DIGIT_W +: DIGIT_W] == DIGIT_MIN);
        end
        at_term_c = (up_dn == DIR_UP) ? all_max_c : all_min_c;
    end

    // In saturate mode the terminal step is suppressed at its source so no digit moves.
    assign step_c[0] = en & ~(SATURATE & at_term_c);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .clr_i      (clr),
            .load_i     (load),
            .load_nib_i (load_val[g*DIGIT_W +: DIGIT_W]),
            .step_i     (step_c[g]),
            .up_i       (up_dn),
            .digit_o    (count[g*DIGIT_W +: DIGIT_W]),
            .carry_c_o  (step_c[g+1])
        );
    end

    // A carry out of the top digit is exactly a wrap; saturation is flagged directly.
    assign ovf_set_c = step_c[DIGITS] | (SATURATE & en & at_term_c);

    always_comb begin
        ovf_d = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
        end else if (!load && ovf_set_c) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
    assign tc  = en & ~clr & ~load & ~rst & at_term_c;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench: a wrapping and a saturating counter driven in parallel,
// checked against spec constants and an integer-valued reference model.
module tb_bcd_cascade_counter;

    localparam int unsigned ND   = 4;
    localparam int          NMAX = 9999;

    logic          clk = 1'b0;
    logic          rst, en, up_dn, clr, load;
    logic [15:0]   load_val;
    logic [15:0]   count_w, count_s;
    logic          tc_w, tc_s, ovf_w, ovf_s;

    int errors = 0;
    int checks = 0;

    // Reference model state: plain integers for the count value.
    int mw, ms;
    bit ow, os;

    always #5 clk = ~clk;

    bcd_cascade_counter #(.DIGITS(ND), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(count_w), .tc(tc_w), .ovf(ovf_w)
    );

    bcd_cascade_counter #(.DIGITS(ND), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(count_s), .tc(tc_s), .ovf(ovf_s)
    );

    function automatic int load_to_int(input logic [15:0] v);
        int acc = 0;
        int w = 1;
        for (int i = 0; i < 4; i++) begin
            int nib = int'((v >> (4*i)) & 16'hF);
            if (nib > 9) nib = 9;
            acc += nib * w;
            w *= 10;
        end
        return acc;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r = r | (16'((t % 10)) << (4*i));
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit model_tc(input int m);
        return en && !clr && !load && !rst && (up_dn ? (m == NMAX) : (m == 0));
    endfunction

    task automatic drive(input logic r, input logic e, input logic u,
                         input logic c, input logic l, input logic [15:0] lv);
        @(negedge clk);
        rst = r; en = e; up_dn = u; clr = c; load = l; load_val = lv;
        #1;
    endtask

    // Advance one edge and move the reference model by the same sampled inputs.
    task automatic tick();
        int nw = mw, ns = ms;
        bit vw = ow, vs = os;
        if (rst || clr) begin
            nw = 0; ns = 0; vw = 0; vs = 0;
        end else if (load) begin
            nw = load_to_int(load_val); ns = nw;
        end else if (en) begin
            if (up_dn) begin
                if (mw == NMAX) begin nw = 0; vw = 1; end else nw = mw + 1;
                if (ms == NMAX) vs = 1; else ns = ms + 1;
            end else begin
                if (mw == 0) begin nw = NMAX; vw = 1; end else nw = mw - 1;
                if (ms == 0) vs = 1; else ns = ms - 1;
            end
        end
        @(posedge clk);
        mw = nw; ms = ns; ow = vw; os = vs;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 0, 1, 16'h1234);
        tick();
        checks++;
        if (count_w !== 16'h0000 || count_s !== 16'h0000) begin
            errors++;
            $display("FAIL reset_count: got %h/%h want 0000", count_w, count_s);
        end
        checks++;
        if (ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b/%b want 0", ovf_w, ovf_s);
        end
        drive(1, 1, 0, 0, 0, 16'h0000);
        checks++;
        if (tc_w !== 1'b0 || tc_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc: got %b/%b want 0", tc_w, tc_s);
        end
        tick();
    endtask

    task automatic test_up_cascade();
        drive(0, 0, 1, 0, 1, 16'h0999);
        tick();
        drive(0, 1, 1, 0, 0, 16'h0000);
        checks++;
        if (tc_w !== 1'b0) begin
            errors++;
            $display("FAIL cascade_tc: got %b want 0", tc_w);
        end
        tick();
        checks++;
        if (count_w !== 16'h1000 || count_s !== 16'h1000) begin
            errors++;
            $display("FAIL cascade_count: got %h/%h want 1000", count_w, count_s);
        end
        checks++;
        if (ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL cascade_ovf: got %b/%b want 0", ovf_w, ovf_s);
        end
    endtask

    task automatic test_up_wrap();
        drive(0, 0, 1, 0, 1, 16'h9998);
        tick();
        drive(0, 1, 1, 0, 0, 16'h0000);
        tick();
        checks++;
        if (count_w !== 16'h9999) begin
            errors++;
            $display("FAIL wrap_first: got %h want 9999", count_w);
        end
        checks++;
        if (tc_w !== 1'b1 || tc_s !== 1'b1) begin
            errors++;
            $display("FAIL wrap_tc: got %b/%b want 1", tc_w, tc_s);
        end
        tick();
        checks++;
        if (count_w !== 16'h0000 || ovf_w !== 1'b1) begin
            errors++;
            $display("FAIL wrap_second: got %h ovf=%b want 0000 ovf=1", count_w, ovf_w);
        end
        checks++;
        if (count_s !== 16'h9999 || ovf_s !== 1'b1) begin
            errors++;
            $display("FAIL wrap_sat_hold: got %h ovf=%b want 9999 ovf=1", count_s, ovf_s);
        end
    endtask

    task automatic test_down_saturate();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h0000; exp_w[1] = 16'h9999; exp_w[2] = 16'h9998;
        drive(0, 0, 1, 1, 0, 16'h0000);
        tick();
        drive(0, 0, 0, 0, 1, 16'h0001);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 16'h0000);
            if (i > 0) begin
                checks++;
                if (tc_s !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_tc[%0d]: got %b want 1", i, tc_s);
                end
            end
            tick();
            checks++;
            if (count_s !== 16'h0000 || count_w !== exp_w[i]) begin
                errors++;
                $display("FAIL sat_down[%0d]: got %h/%h want 0000/%h", i, count_s, count_w, exp_w[i]);
            end
        end
        checks++;
        if (ovf_s !== 1'b1 || ovf_w !== 1'b1) begin
            errors++;
            $display("FAIL sat_ovf: got %b/%b want 1", ovf_s, ovf_w);
        end
    endtask

    task automatic test_clamp_priority();
        drive(0, 1, 1, 0, 1, 16'hFA3C);
        tick();
        checks++;
        if (count_w !== 16'h9939 || count_s !== 16'h9939) begin
            errors++;
            $display("FAIL clamp_load: got %h/%h want 9939", count_w, count_s);
        end
        checks++;
        if (ovf_w !== 1'b1 || ovf_s !== 1'b1) begin
            errors++;
            $display("FAIL load_keeps_ovf: got %b/%b want 1", ovf_w, ovf_s);
        end
        drive(0, 1, 1, 1, 1, 16'h5555);
        tick();
        checks++;
        if (count_w !== 16'h0000 || ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL clr_over_load: got %h ovf=%b/%b want 0000 ovf=0", count_w, ovf_w, ovf_s);
        end
    endtask

    task automatic test_direction_flip();
        logic [15:0] exp_c [4];
        exp_c[0] = 16'h0011; exp_c[1] = 16'h0010; exp_c[2] = 16'h0011; exp_c[3] = 16'h0010;
        drive(0, 0, 1, 0, 1, 16'h0010);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, (i % 2 == 0), 0, 0, 16'h0000);
            tick();
            checks++;
            if (count_w !== exp_c[i] || ovf_w !== 1'b0) begin
                errors++;
                $display("FAIL dir_flip[%0d]: got %h ovf=%b want %h ovf=0", i, count_w, ovf_w, exp_c[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] lv;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: lv = 16'h9999;
                1: lv = 16'h0000;
                2: lv = 16'(16'h9990 | 16'($urandom_range(0, 15)));
                default: lv = 16'($urandom);
            endcase
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) == 0), lv);
            checks++;
            if (tc_w !== model_tc(mw) || tc_s !== model_tc(ms)) begin
                errors++;
                $display("FAIL rand_tc[%0d]: got %b/%b want %b/%b", n, tc_w, tc_s, model_tc(mw), model_tc(ms));
            end
            tick();
            checks++;
            if (count_w !== int_to_bcd(mw) || ovf_w !== ow) begin
                errors++;
                $display("FAIL rand_wrap[%0d]: got %h ovf=%b want %h ovf=%b", n, count_w, ovf_w, int_to_bcd(mw), ow);
            end
            checks++;
            if (count_s !== int_to_bcd(ms) || ovf_s !== os) begin
                errors++;
                $display("FAIL rand_sat[%0d]: got %h ovf=%b want %h ovf=%b", n, count_s, ovf_s, int_to_bcd(ms), os);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
        mw = 0; ms = 0; ow = 0; os = 0;
        test_reset();
        test_up_cascade();
        test_up_wrap();
        test_down_saturate();
        test_clamp_priority();
        test_direction_flip();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
